quad_velocity: RTL and testbench
================================

Name: quad_velocity

Overview:
- Downstream consumer of the millisecond timer pulse in the quadrature peripheral.
- Synchronizes and decodes one quadrature encoder (A/B), with 4x decoding.
- Maintains a wrapping position count.
- On each sample_pulse, latches the signed edge count accumulated over the past interval as a speed value and strobes speed_valid.
- Sticky error flag flags illegal A/B transitions.

Parameters:
- COUNT_WIDTH, 16, width of position counter and interval accumulator.
- SPEED_WIDTH, 8, width of signed latched speed (saturating).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- quad_a  input  1  encoder channel A, asynchronous.
- quad_b  input  1  encoder channel B, asynchronous.
- sample_pulse  input  1  one-cycle strobe from the interval timer.
- err_clear  input  1  clears the sticky error flag.
- enc_count  output  COUNT_WIDTH  position count, two's-complement, wraps.
- speed  output  SPEED_WIDTH  signed edges per interval.
- speed_valid  output  1  one-cycle strobe; speed was just updated.
- dir  output  1  direction of last legal step: 1 = forward, 0 = reverse.
- err  output  1  sticky; set on an illegal transition.

Behaviour:
- Reset (synchronous, active-high): all outputs and internal registers go to 0, including sync flops, prev state, accumulator and primed counter.
- Synchronizer:
  - A and B each pass through 2 flops; cur = {A_s, B_s}.
  - Decode compares cur to prev; prev <= cur every cycle.
- Priming:
  - For the first 3 cycles after reset deasserts, prev tracks cur with no count, no dir change and no err.
  - Counting and error detection start on cycle 4.
- Decode (2-bit state {A,B}):
  - Forward (+1): 00->10, 10->11, 11->01, 01->00.
  - Reverse (-1): 00->01, 01->11, 11->10, 10->00.
  - Unchanged: step 0.
  - Both bits change: illegal; step 0, err <= 1.
- enc_count:
  - enc_count <= enc_count + step, modulo 2^COUNT_WIDTH; 0x7FFF + 1 = 0x8000, 0x0000 - 1 = 0xFFFF.
  - Latency: a quad_a/quad_b edge reaches enc_count 3 clk after it is sampled (2 sync + 1 decode).
- dir: updated only on a nonzero step; holds otherwise.
- Accumulator acc (signed, COUNT_WIDTH bits):
  - acc <= acc + step, saturating at +2^(COUNT_WIDTH-1)-1 and -2^(COUNT_WIDTH-1); never wraps.
- On sample_pulse:
  - total = acc + step, where step is the step of the same cycle.
  - speed <= total saturated to SPEED_WIDTH signed range (+127 / -128 at default).
  - acc <= 0.
  - speed_valid <= 1 for exactly the next cycle.
  - The same-cycle step is counted in this interval, not the next.
- sample_pulse held high for consecutive cycles: each cycle latches and clears, so the 2nd cycle latches only that cycle's step.
- speed holds its value between pulses; speed_valid is 0 except the cycle after a pulse.
- err:
  - err_clear clears err.
  - If an illegal transition and err_clear occur in the same cycle, set wins: err = 1.
- Reset mid-interval discards acc; the next pulse after re-priming reports only post-reset steps.

Optional Feature:
- Macro: QUAD_VELOCITY_FILTER_EN.
- Defined:
  - A 3-cycle stability filter sits after the synchronizer per channel.
  - The filtered channel updates only when the synchronized value has been stable for 3 consecutive cycles.
  - Pulses shorter than 3 clk are rejected.
  - Edge-to-enc_count latency becomes 6 clk.
  - Priming extends to 6 cycles.
- Not defined: no filter; latency 3 clk; priming 3 cycles.

Test Plan:
- Reset release with A=1,B=1 held: after 10 cycles, enc_count = 0, err = 0, dir = 0, speed = 0, speed_valid never high.
- 20 forward steps (states 00->10->11->01->00 repeated, 8 clk per state) then one sample_pulse: enc_count = 20; speed = 20, with speed_valid high exactly 1 cycle after the pulse; dir = 1.
- 5 reverse steps from count 0: enc_count = 0xFFFB; next pulse gives speed = -5 (0xFB); dir = 0.
- 300 forward steps within one interval: speed = 127 (saturated); enc_count = 300. Next interval with no motion: speed = 0.
- A step arriving in the same cycle as sample_pulse: included in the latched speed; next interval starts at 0.
- Force 00->11 jump: err = 1, enc_count unchanged. Assert err_clear in the same cycle as a second 11->00 jump: err stays 1. Then err_clear alone: err = 0.
- (Filter build) 2-cycle glitch on A: no count change. 4-cycle-stable edge: counts, with 6 clk latency.

Source files
------------

// File: rtl/quad_velocity.sv
// -----------------------------------------------------------------------------
// quad_velocity
//
// Purpose:
//   Quadrature encoder front end for the quadrature peripheral. Synchronizes
//   one A/B encoder pair, performs 4x decoding, keeps a wrapping position
//   count, and on every sample_pulse from the interval timer latches the signed
//   number of edges seen during the interval as a saturated speed value.
//   Illegal transitions (both channels changing at once) set a sticky error.
//
// Optional feature:
//   QUAD_VELOCITY_FILTER_EN - when defined, each synchronized channel passes
//   through a 3-cycle stability filter. Pulses shorter than 3 clk are rejected,
//   edge-to-enc_count latency grows from 3 to 6 clk and priming from 3 to 6
//   cycles.
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   quad_a       in   encoder channel A (asynchronous)
//   quad_b       in   encoder channel B (asynchronous)
//   sample_pulse in   one-cycle strobe from the interval timer
//   err_clear    in   clears the sticky error flag
//   enc_count    out  position count, two's complement, wraps
//   speed        out  signed edges per interval, saturated
//   speed_valid  out  one-cycle strobe, speed just updated
//   dir          out  direction of last legal step (1 = forward)
//   err          out  sticky illegal-transition flag
// -----------------------------------------------------------------------------
module quad_velocity #(
  parameter int COUNT_WIDTH = 16,
  parameter int SPEED_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   quad_a,
  input  logic                   quad_b,
  input  logic                   sample_pulse,
  input  logic                   err_clear,
  output logic [COUNT_WIDTH-1:0] enc_count,
  output logic [SPEED_WIDTH-1:0] speed,
  output logic                   speed_valid,
  output logic                   dir,
  output logic                   err
);

`ifdef QUAD_VELOCITY_FILTER_EN
  localparam logic [2:0] LP_PRIME = 3'd6;
`else
  localparam logic [2:0] LP_PRIME = 3'd3;
`endif

  // Speed limits expressed at accumulator-plus-one width so the comparison
  // against the unsaturated total is a plain signed compare.
  localparam logic signed [COUNT_WIDTH:0] LP_SPD_MAX =
    (COUNT_WIDTH+1)'(2**(SPEED_WIDTH-1) - 1);
  localparam logic signed [COUNT_WIDTH:0] LP_SPD_MIN = ~LP_SPD_MAX;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers
  // ---------------------------------------------------------------------------
  logic r_a_meta, r_a_sync, r_b_meta, r_b_sync;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_meta <= 1'b0;
      r_a_sync <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_sync <= 1'b0;
    end else begin
      r_a_meta <= quad_a;
      r_a_sync <= r_a_meta;
      r_b_meta <= quad_b;
      r_b_sync <= r_b_meta;
    end
  end

  logic [1:0] w_cur;

`ifdef QUAD_VELOCITY_FILTER_EN
  // ---------------------------------------------------------------------------
  // Stability filter: the filtered value follows the synchronized value only
  // after it has differed for 3 consecutive samples; any return to the
  // filtered value restarts the count.
  // ---------------------------------------------------------------------------
  logic       r_a_filt, r_b_filt;
  logic [1:0] r_a_cnt, r_b_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_filt <= 1'b0;
      r_b_filt <= 1'b0;
      r_a_cnt  <= 2'd0;
      r_b_cnt  <= 2'd0;
    end else begin
      if (r_a_sync == r_a_filt) begin
        r_a_cnt <= 2'd0;
      end else if (r_a_cnt == 2'd2) begin
        r_a_filt <= r_a_sync;
        r_a_cnt  <= 2'd0;
      end else begin
        r_a_cnt <= r_a_cnt + 2'd1;
      end

      if (r_b_sync == r_b_filt) begin
        r_b_cnt <= 2'd0;
      end else if (r_b_cnt == 2'd2) begin
        r_b_filt <= r_b_sync;
        r_b_cnt  <= 2'd0;
      end else begin
        r_b_cnt <= r_b_cnt + 2'd1;
      end
    end
  end

  assign w_cur = {r_a_filt, r_b_filt};
`else
  assign w_cur = {r_a_sync, r_b_sync};
`endif

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic [1:0]                    r_prev;
  logic [2:0]                    r_prime_cnt;
  logic [COUNT_WIDTH-1:0]        r_count;
  logic signed [COUNT_WIDTH-1:0] r_acc;
  logic [SPEED_WIDTH-1:0]        r_speed;
  logic                          r_speed_valid;
  logic                          r_dir;
  logic                          r_err;

  logic                          w_primed;
  logic [1:0]                    w_diff;
  logic signed [1:0]             w_step;
  logic                          w_illegal;
  logic signed [COUNT_WIDTH:0]   w_step_ext;
  logic signed [COUNT_WIDTH:0]   w_total;
  logic signed [COUNT_WIDTH-1:0] w_acc_next;
  logic [SPEED_WIDTH-1:0]        w_speed_next;

  // Position of a state along the forward Gray sequence 00->10->11->01.
  // The modulo-4 difference of two positions gives the step directly:
  // 1 forward, 3 reverse, 2 illegal, 0 no change.
  function automatic logic [1:0] gray_pos(input logic [1:0] s);
    case (s)
      2'b00:   gray_pos = 2'd0;
      2'b10:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  assign w_primed = (r_prime_cnt == LP_PRIME);
  assign w_diff   = gray_pos(w_cur) - gray_pos(r_prev);

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_step    = 2'sd0;
    w_illegal = 1'b0;
    if (w_primed) begin
      case (w_diff)
        2'd1:    w_step    = 2'sd1;
        2'd3:    w_step    = -2'sd1;
        2'd2:    w_illegal = 1'b1;
        default: w_step    = 2'sd0;
      endcase
    end
  end

  assign w_step_ext = {{(COUNT_WIDTH-1){w_step[1]}}, w_step};
  // One guard bit makes overflow of acc + step visible in the top two bits.
  assign w_total    = {r_acc[COUNT_WIDTH-1], r_acc} + w_step_ext;

  always_comb begin
    w_acc_next = w_total[COUNT_WIDTH-1:0];
    if (w_total[COUNT_WIDTH] != w_total[COUNT_WIDTH-1]) begin
      w_acc_next = w_total[COUNT_WIDTH] ? {1'b1, {(COUNT_WIDTH-1){1'b0}}}
                                        : {1'b0, {(COUNT_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    w_speed_next = w_total[SPEED_WIDTH-1:0];
    if (w_total > LP_SPD_MAX) begin
      w_speed_next = LP_SPD_MAX[SPEED_WIDTH-1:0];
    end else if (w_total < LP_SPD_MIN) begin
      w_speed_next = LP_SPD_MIN[SPEED_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev        <= 2'b00;
      r_prime_cnt   <= 3'd0;
      r_count       <= '0;
      r_acc         <= '0;
      r_speed       <= '0;
      r_speed_valid <= 1'b0;
      r_dir         <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_prev        <= w_cur;
      r_speed_valid <= sample_pulse;
      r_count       <= r_count + w_step_ext[COUNT_WIDTH-1:0];

      if (!w_primed) begin
        r_prime_cnt <= r_prime_cnt + 3'd1;
      end

      if (w_step != 2'sd0) begin
        r_dir <= ~w_step[1];
      end

      // The same-cycle step belongs to the interval being closed.
      if (sample_pulse) begin
        r_speed <= w_speed_next;
        r_acc   <= '0;
      end else begin
        r_acc   <= w_acc_next;
      end

      // Set has priority over clear.
      if (w_illegal) begin
        r_err <= 1'b1;
      end else if (err_clear) begin
        r_err <= 1'b0;
      end
    end
  end

  assign enc_count   = r_count;
  assign speed       = r_speed;
  assign speed_valid = r_speed_valid;
  assign dir         = r_dir;
  assign err         = r_err;

endmodule

// File: tb/tb_quad_velocity.sv
// -----------------------------------------------------------------------------
// tb_quad_velocity
//
// Purpose:
//   Directed self-checking bench for quad_velocity (default parameters).
//   Expected speed values go into a scoreboard queue when a sample pulse is
//   driven and are popped when speed_valid appears. Position, direction and
//   error flag are compared against a small behavioural model.
//   Honours QUAD_VELOCITY_FILTER_EN for latency, priming and glitch tests.
// -----------------------------------------------------------------------------
module tb_quad_velocity;

`ifdef QUAD_VELOCITY_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = 8;

  logic        clk;
  logic        reset;
  logic        quad_a;
  logic        quad_b;
  logic        sample_pulse;
  logic        err_clear;
  logic [15:0] enc_count;
  logic [7:0]  speed;
  logic        speed_valid;
  logic        dir;
  logic        err;

  quad_velocity #(.COUNT_WIDTH(16), .SPEED_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .quad_a       (quad_a),
    .quad_b       (quad_b),
    .sample_pulse (sample_pulse),
    .err_clear    (err_clear),
    .enc_count    (enc_count),
    .speed        (speed),
    .speed_valid  (speed_valid),
    .dir          (dir),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb[$];

  // Behavioural model state.
  int         m_pos;
  int         m_acc;
  logic       m_dir;
  logic [1:0] m_ab;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sat8(input int v);
    if (v > 127)  return 8'h7F;
    if (v < -128) return 8'h80;
    return 8'(v);
  endfunction

  function automatic logic [1:0] next_state(input logic [1:0] s, input bit fwd);
    if (fwd) begin
      case (s)
        2'b00: return 2'b10;
        2'b10: return 2'b11;
        2'b11: return 2'b01;
        default: return 2'b00;
      endcase
    end else begin
      case (s)
        2'b00: return 2'b01;
        2'b01: return 2'b11;
        2'b11: return 2'b10;
        default: return 2'b00;
      endcase
    end
  endfunction

  // Drive one legal step right after a rising edge and update the model.
  task automatic drive_step(input bit fwd);
    @(posedge clk);
    #1;
    m_ab   = next_state(m_ab, fwd);
    quad_a = m_ab[1];
    quad_b = m_ab[0];
    m_pos  = m_pos + (fwd ? 1 : -1);
    m_acc  = m_acc + (fwd ? 1 : -1);
    m_dir  = fwd;
  endtask

  task automatic move(input bit fwd, input int n);
    for (int i = 0; i < n; i++) begin
      drive_step(fwd);
      repeat (HOLD - 1) @(posedge clk);
    end
  endtask

  task automatic pulse();
    @(posedge clk);
    #1;
    sample_pulse = 1'b1;
    sb.push_back(sat8(m_acc));
    m_acc = 0;
    @(posedge clk);
    #1;
    sample_pulse = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    m_pos = 0;
    m_acc = 0;
    m_dir = 1'b0;
    repeat (LAT + 6) @(posedge clk);
  endtask

  // Scoreboard consumer: every speed_valid must match a queued expectation.
  always @(negedge clk) begin
    if (speed_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(speed_valid), 32'd0);
      end else begin
        automatic logic [7:0] exp_spd = sb.pop_front();
        check("speed", {24'd0, speed}, {24'd0, exp_spd});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] pos_before;

    reset        = 1'b1;
    quad_a       = 1'b1;
    quad_b       = 1'b1;
    sample_pulse = 1'b0;
    err_clear    = 1'b0;
    m_ab         = 2'b11;
    m_pos        = 0;
    m_acc        = 0;
    m_dir        = 1'b0;

    // Reset release with A=B=1 held: priming must not count anything.
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_count", 32'(enc_count), 32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_dir",   32'(dir),       32'd0);
    check("rst_speed", 32'(speed),     32'd0);
    check("rst_valid", 32'(speed_valid), 32'd0);

    // 20 forward steps, one pulse; speed_valid exactly one cycle.
    move(1'b1, 20);
    pulse();
    @(negedge clk);
    check("valid_hi", 32'(speed_valid), 32'd1);
    @(negedge clk);
    check("valid_lo", 32'(speed_valid), 32'd0);
    check("fwd_count", 32'(enc_count), 32'(m_pos[15:0]));
    check("fwd_dir",   32'(dir),       32'(m_dir));

    // Steps before a mid-interval reset must be discarded.
    move(1'b1, 3);
    do_reset();
    check("mid_rst_count", 32'(enc_count), 32'd0);

    // 5 reverse steps from 0 -> 0xFFFB, speed -5.
    move(1'b0, 5);
    @(negedge clk);
    check("rev_count", 32'(enc_count), 32'h0000_FFFB);
    check("rev_dir",   32'(dir),       32'd0);
    pulse();
    repeat (3) @(posedge clk);

    // 300 forward steps from 0: saturated speed, then an idle interval.
    do_reset();
    move(1'b1, 300);
    @(negedge clk);
    check("sat_count", 32'(enc_count), 32'd300);
    pulse();
    repeat (20) @(posedge clk);
    pulse();
    repeat (3) @(posedge clk);

    // Edge-to-count latency.
    pos_before = enc_count;
    drive_step(1'b1);
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk);
    check("lat_early", 32'(enc_count), 32'(pos_before));
    @(posedge clk);
    @(negedge clk);
    check("lat_edge",  32'(enc_count), 32'(m_pos[15:0]));
    repeat (HOLD) @(posedge clk);

    // Step landing on the same cycle as sample_pulse counts in that interval.
    pulse();
    move(1'b1, 3);
    drive_step(1'b1);
    repeat (LAT - 1) @(posedge clk);
    #1;
    sample_pulse = 1'b1;
    sb.push_back(sat8(m_acc));
    m_acc = 0;
    @(posedge clk);
    #1;
    sample_pulse = 1'b0;
    repeat (HOLD) @(posedge clk);
    move(1'b1, 2);
    pulse();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("same_cyc_count", 32'(enc_count), 32'(m_pos[15:0]));

`ifdef QUAD_VELOCITY_FILTER_EN
    // A 2-cycle glitch on A is rejected by the filter.
    pos_before = enc_count;
    @(posedge clk);
    #1;
    quad_a = ~m_ab[1];
    repeat (2) @(posedge clk);
    #1;
    quad_a = m_ab[1];
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("glitch_count", 32'(enc_count), 32'(pos_before));
    check("glitch_err",   32'(err),       32'd0);
`endif

    // Walk to state 00, then force an illegal 00->11 jump.
    while (m_ab != 2'b00) move(1'b1, 1);
    pulse();
    pos_before = enc_count;
    @(posedge clk);
    #1;
    quad_a = 1'b1;
    quad_b = 1'b1;
    m_ab   = 2'b11;
    repeat (HOLD) @(posedge clk);
    @(negedge clk);
    check("ill_err",   32'(err),       32'd1);
    check("ill_count", 32'(enc_count), 32'(pos_before));

    // Second illegal jump 11->00 with err_clear on the same decode cycle.
    @(posedge clk);
    #1;
    quad_a = 1'b0;
    quad_b = 1'b0;
    m_ab   = 2'b00;
    repeat (LAT - 1) @(posedge clk);
    #1;
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    @(negedge clk);
    check("set_wins", 32'(err), 32'd1);

    // err_clear alone clears.
    repeat (4) @(posedge clk);
    #1;
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    @(negedge clk);
    check("err_cleared", 32'(err),       32'd0);
    check("ill_count2",  32'(enc_count), 32'(pos_before));
    check("ill_dir",     32'(dir),       32'(m_dir));

    // Nothing left undelivered in the scoreboard.
    repeat (5) @(posedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
